// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//
// Bundles the byte-stream handshake, the instruction-memory write port and
// the boot status lines of the instruction-memory loader.
//
//   start       load request, one cycle wide
//   word_count  number of words to load (legal 1..256), sampled with start
//   byte_in     stream data byte
//   byte_valid  byte_in holds a valid byte
//   byte_ready  loader can accept a byte (transfer on valid && ready)
//   im_we       instruction-memory write enable, one pulse per word
//   im_addr     instruction-memory word address
//   im_wdata    instruction-memory write data
//   cpu_hold    keeps the processor pipeline in reset
//   load_done   last load finished successfully
//   load_err    last start was rejected or the last load timed out
//
// The master modport is the boot host / stream source side, the slave
// modport is the loader itself.
// ---------------------------------------------------------------------------
interface imem_loader_if;
    logic        start;
    logic [8:0]  word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    modport master (
        output start,
        output word_count,
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata,
        input  cpu_hold,
        input  load_done,
        input  load_err
    );

    modport slave (
        input  start,
        input  word_count,
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output im_we,
        output im_addr,
        output im_wdata,
        output cpu_hold,
        output load_done,
        output load_err
    );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time writer for the 256 x 32-bit instruction memory. Bytes arriving
// on a valid/ready stream are packed big-endian (first byte in [31:24]) into
// 32-bit words, which are written to consecutive addresses starting at 0.
// The processor pipeline is held in reset (cpu_hold) until a load finishes
// without error.
//
// Parameters
//   TIMEOUT  idle cycles allowed between accepted bytes while loading
//            (2..65535)
//
// Ports
//   clk      system clock, rising-edge
//   rst_n    asynchronous active-low reset
//   bus      imem_loader_if.slave: stream input, memory write port, status
//
// All outputs are registered. The FSM walks IDLE -> RECV -> WRITE -> ... ->
// DONE; WRITE always lasts exactly one cycle, so with byte_valid held high
// a word costs four RECV cycles plus one WRITE cycle.
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Terminal value of the idle counter; reaching it without a byte aborts.
    localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    logic [1:0]  state,      state_nx;
    logic [8:0]  word_cnt,   word_cnt_nx;
    logic [7:0]  last_word,  last_word_nx;
    logic [1:0]  byte_cnt,   byte_cnt_nx;
    logic [15:0] idle_cnt,   idle_cnt_nx;

    logic        ready_reg,  ready_nx;
    logic        we_reg,     we_nx;
    logic [7:0]  addr_reg,   addr_nx;
    logic [31:0] wdata_reg,  wdata_nx;
    logic        hold_reg,   hold_nx;
    logic        done_reg,   done_nx;
    logic        err_reg,    err_nx;

    // Assembly shift register; only ever read after four fresh shifts, so
    // it carries no reset.
    logic [31:0] asm_word;

    logic        accept;
    logic        count_ok;
    logic        start_ok;
    logic        start_bad;

    // ready_reg is high exactly while in RECV, so it doubles as the
    // "accepting" qualifier for the handshake.
    assign accept    = ready_reg && bus.byte_valid;
    assign count_ok  = (bus.word_count != 9'd0) && (bus.word_count <= 9'd256);
    assign start_ok  = bus.start && count_ok;
    assign start_bad = bus.start && !count_ok;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx     = state;
        word_cnt_nx  = word_cnt;
        last_word_nx = last_word;
        byte_cnt_nx  = byte_cnt;
        idle_cnt_nx  = idle_cnt;
        ready_nx     = ready_reg;
        we_nx        = 1'b0;
        addr_nx      = addr_reg;
        wdata_nx     = wdata_reg;
        hold_nx      = hold_reg;
        done_nx      = done_reg;
        err_nx       = err_reg;

        case (state)
            // Start is only honoured when no load is in flight.
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_nx     = S_RECV;
                    word_cnt_nx  = 9'd0;
                    byte_cnt_nx  = 2'd0;
                    idle_cnt_nx  = 16'd0;
                    // 256 wraps to 8'h00, minus one gives 8'hFF as intended.
                    last_word_nx = bus.word_count[7:0] - 8'd1;
                    ready_nx     = 1'b1;
                    hold_nx      = 1'b1;
                    done_nx      = 1'b0;
                    err_nx       = 1'b0;
                end else if (start_bad) begin
                    state_nx = S_IDLE;
                    hold_nx  = 1'b1;
                    done_nx  = 1'b0;
                    err_nx   = 1'b1;
                end
            end

            S_RECV: begin
                if (accept) begin
                    idle_cnt_nx = 16'd0;
                    byte_cnt_nx = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        state_nx = S_WRITE;
                        ready_nx = 1'b0;
                        we_nx    = 1'b1;
                        addr_nx  = word_cnt[7:0];
                        wdata_nx = {asm_word[23:0], bus.byte_in};
                    end
                end else if (idle_cnt == IDLE_LIMIT) begin
                    // Stream stalled: drop the partial word, keep the CPU held.
                    state_nx = S_IDLE;
                    ready_nx = 1'b0;
                    err_nx   = 1'b1;
                end else begin
                    idle_cnt_nx = idle_cnt + 16'd1;
                end
            end

            S_WRITE: begin
                if (word_cnt == {1'b0, last_word}) begin
                    state_nx = S_DONE;
                    hold_nx  = 1'b0;
                    done_nx  = 1'b1;
                end else begin
                    state_nx    = S_RECV;
                    word_cnt_nx = word_cnt + 9'd1;
                    byte_cnt_nx = 2'd0;
                    idle_cnt_nx = 16'd0;
                    ready_nx    = 1'b1;
                end
            end

            default: begin
                state_nx = S_IDLE;
                ready_nx = 1'b0;
                hold_nx  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            word_cnt  <= 9'd0;
            last_word <= 8'd0;
            byte_cnt  <= 2'd0;
            idle_cnt  <= 16'd0;
            ready_reg <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= 8'h00;
            wdata_reg <= 32'h0;
            hold_reg  <= 1'b1;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state     <= state_nx;
            word_cnt  <= word_cnt_nx;
            last_word <= last_word_nx;
            byte_cnt  <= byte_cnt_nx;
            idle_cnt  <= idle_cnt_nx;
            ready_reg <= ready_nx;
            we_reg    <= we_nx;
            addr_reg  <= addr_nx;
            wdata_reg <= wdata_nx;
            hold_reg  <= hold_nx;
            done_reg  <= done_nx;
            err_reg   <= err_nx;
        end
    end

    // ------------------------------------------------------------------
    // Byte assembly (big-endian: oldest byte ends up in [31:24])
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            asm_word <= {asm_word[23:0], bus.byte_in};
        end
    end

    assign bus.byte_ready = ready_reg;
    assign bus.im_we      = we_reg;
    assign bus.im_addr    = addr_reg;
    assign bus.im_wdata   = wdata_reg;
    assign bus.cpu_hold   = hold_reg;
    assign bus.load_done  = done_reg;
    assign bus.load_err   = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Expected memory contents are built
// from the bytes the bench itself streams (four bytes per word, first byte
// most significant, word i at address i); timing expectations follow the
// cycle rules of the loader (start -> ready next cycle, write the cycle after
// the 4th byte, done the cycle after the last write, timeout after TO idle
// cycles).
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int TO = 8;

    typedef logic [7:0] byte_q_t[$];

    localparam logic [44:0] RESET_VEC = {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst_n;

    imem_loader_if bus();

    imem_loader #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Observed writes {addr, data} and writes seen while byte_ready was high.
    logic [39:0] wr_q[$];
    int          overlap_cnt = 0;

    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            wr_q.push_back({bus.im_addr, bus.im_wdata});
            if (bus.byte_ready === 1'b1) overlap_cnt++;
        end
    end

    function automatic logic [44:0] outs();
        return {bus.byte_ready, bus.im_we, bus.im_addr, bus.im_wdata,
                bus.cpu_hold, bus.load_done, bus.load_err};
    endfunction

    // Reference: word i of a byte stream, first byte most significant.
    function automatic logic [31:0] model_word(input byte_q_t q, input int i);
        logic [31:0] w = 32'h0;
        for (int k = 0; k < 4; k++) w = (w << 8) | 32'(q[4*i + k]);
        return w;
    endfunction

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t q;
        for (int k = 0; k < n; k++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic do_start(input logic [8:0] wc);
        bus.start      = 1'b1;
        bus.word_count = wc;
        @(posedge clk); #1;
        bus.start      = 1'b0;
    endtask

    // Streams all bytes, holding each until it is transferred. Returns with
    // byte_valid low, #1 after the edge that took the last byte.
    task automatic drive_stream(input byte_q_t data, input bit rnd, output bit ok);
        int idx = 0;
        int cyc = 0;
        int lowrun = 0;
        int limit;
        bit v;
        bit rdy;
        limit = 20 * data.size() + 50;
        while (idx < data.size() && cyc < limit) begin
            v = rnd ? (($urandom_range(0, 1) == 1) || lowrun >= 2) : 1'b1;
            bus.byte_valid = v;
            bus.byte_in    = v ? data[idx] : 8'($urandom);
            rdy = bus.byte_ready;
            @(posedge clk); #1;
            cyc++;
            if (v && rdy) idx++;
            lowrun = v ? 0 : lowrun + 1;
        end
        bus.byte_valid = 1'b0;
        ok = (idx == data.size());
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs() !== RESET_VEC) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", outs(), RESET_VEC);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outs() !== RESET_VEC) begin
            failures++;
            $display("FAIL idle_after_reset got=%h exp=%h", outs(), RESET_VEC);
        end
    endtask

    task automatic test_basic();
        logic [7:0]  b [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        logic [31:0] exp_w [2] = '{32'h12345678, 32'h9ABCDEF0};
        wr_q.delete();
        do_start(9'd2);
        checks++;
        if ({bus.byte_ready, bus.cpu_hold, bus.load_done} !== 3'b110) begin
            failures++;
            $display("FAIL basic_start got rdy/hold/done=%b exp=110",
                     {bus.byte_ready, bus.cpu_hold, bus.load_done});
        end
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 4; k++) begin
                bus.byte_valid = 1'b1;
                bus.byte_in    = b[4*w + k];
                @(posedge clk); #1;
            end
            checks++;
            if ({bus.im_we, bus.im_addr, bus.im_wdata, bus.byte_ready} !==
                {1'b1, 8'(w), exp_w[w], 1'b0}) begin
                failures++;
                $display("FAIL basic_write%0d got we=%b addr=%h data=%h rdy=%b exp we=1 addr=%h data=%h rdy=0",
                         w, bus.im_we, bus.im_addr, bus.im_wdata, bus.byte_ready, 8'(w), exp_w[w]);
            end
            if (w == 0) begin
                // Next byte offered during the write cycle must not be taken.
                bus.byte_in = b[4];
                @(posedge clk); #1;
                checks++;
                if ({bus.byte_ready, bus.im_we} !== 2'b10) begin
                    failures++;
                    $display("FAIL basic_ready_after_write got rdy/we=%b exp=10",
                             {bus.byte_ready, bus.im_we});
                end
            end
        end
        bus.byte_in = 8'hAA;
        @(posedge clk); #1;
        checks++;
        if ({bus.load_done, bus.cpu_hold, bus.byte_ready, bus.im_we} !== 4'b1000) begin
            failures++;
            $display("FAIL basic_done got done/hold/rdy/we=%b exp=1000",
                     {bus.load_done, bus.cpu_hold, bus.byte_ready, bus.im_we});
        end
        repeat (3) @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        checks++;
        if (wr_q.size() !== 2 || bus.byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_write_count got writes=%0d rdy=%b exp writes=2 rdy=0",
                     wr_q.size(), bus.byte_ready);
        end
    endtask

    task automatic test_illegal_count();
        byte_q_t d;
        bit ok;
        wr_q.delete();
        do_start(9'd0);
        checks++;
        if ({bus.load_err, bus.load_done, bus.cpu_hold, bus.byte_ready} !== 4'b1010) begin
            failures++;
            $display("FAIL illegal_zero got err/done/hold/rdy=%b exp=1010",
                     {bus.load_err, bus.load_done, bus.cpu_hold, bus.byte_ready});
        end
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h55;
        do_start(9'd300);
        checks++;
        if ({bus.load_err, bus.byte_ready} !== 2'b10) begin
            failures++;
            $display("FAIL illegal_300 got err/rdy=%b exp=10", {bus.load_err, bus.byte_ready});
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (wr_q.size() !== 0 || bus.byte_ready !== 1'b0) begin
            failures++;
            $display("FAIL illegal_no_write got writes=%0d rdy=%b exp writes=0 rdy=0",
                     wr_q.size(), bus.byte_ready);
        end
        bus.byte_valid = 1'b0;
        do_start(9'd1);
        checks++;
        if ({bus.load_err, bus.byte_ready, bus.cpu_hold} !== 3'b011) begin
            failures++;
            $display("FAIL illegal_then_legal got err/rdy/hold=%b exp=011",
                     {bus.load_err, bus.byte_ready, bus.cpu_hold});
        end
        d = rand_bytes(4);
        drive_stream(d, 1'b0, ok);
        @(posedge clk); #1;
        checks++;
        if (!ok || wr_q.size() !== 1 || wr_q[0] !== {8'h00, model_word(d, 0)} ||
            bus.load_done !== 1'b1) begin
            failures++;
            $display("FAIL illegal_recover_load got ok=%0d writes=%0d done=%b exp one write %h",
                     ok, wr_q.size(), bus.load_done, {8'h00, model_word(d, 0)});
        end
    endtask

    task automatic test_timeout();
        byte_q_t d;
        bit ok;
        wr_q.delete();
        do_start(9'd4);
        checks++;
        if ({bus.cpu_hold, bus.load_done, bus.byte_ready} !== 3'b101) begin
            failures++;
            $display("FAIL restart_from_done got hold/done/rdy=%b exp=101",
                     {bus.cpu_hold, bus.load_done, bus.byte_ready});
        end
        d = rand_bytes(5);
        drive_stream(d, 1'b0, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL timeout_stream got bytes_taken=incomplete exp=5");
        end
        for (int j = 1; j <= TO; j++) begin
            @(posedge clk); #1;
            checks++;
            if (j < TO) begin
                if ({bus.load_err, bus.byte_ready} !== 2'b01) begin
                    failures++;
                    $display("FAIL timeout_early cycle=%0d got err/rdy=%b exp=01",
                             j, {bus.load_err, bus.byte_ready});
                end
            end else begin
                if ({bus.load_err, bus.byte_ready, bus.cpu_hold, bus.load_done} !== 4'b1010) begin
                    failures++;
                    $display("FAIL timeout_fire got err/rdy/hold/done=%b exp=1010",
                             {bus.load_err, bus.byte_ready, bus.cpu_hold, bus.load_done});
                end
            end
        end
        checks++;
        if (wr_q.size() !== 1 || wr_q[0] !== {8'h00, model_word(d, 0)}) begin
            failures++;
            $display("FAIL timeout_writes got writes=%0d first=%h exp 1 write %h",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 40'h0, {8'h00, model_word(d, 0)});
        end
        bus.byte_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.byte_ready !== 1'b0 || wr_q.size() !== 1) begin
                failures++;
                $display("FAIL timeout_idle cycle=%0d got rdy=%b writes=%0d exp rdy=0 writes=1",
                         j, bus.byte_ready, wr_q.size());
            end
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic test_random_valid();
        byte_q_t d;
        bit ok;
        int wc;
        overlap_cnt = 0;
        for (int l = 0; l < 4; l++) begin
            wc = $urandom_range(1, 12);
            d  = rand_bytes(4 * wc);
            wr_q.delete();
            do_start(9'(wc));
            drive_stream(d, 1'b1, ok);
            checks++;
            if (!ok || bus.im_we !== 1'b1) begin
                failures++;
                $display("FAIL rand_stream load=%0d got ok=%0d we=%b exp ok=1 we=1",
                         l, ok, bus.im_we);
            end
            @(posedge clk); #1;
            checks++;
            if ({bus.load_done, bus.cpu_hold, bus.load_err} !== 3'b100) begin
                failures++;
                $display("FAIL rand_done load=%0d got done/hold/err=%b exp=100",
                         l, {bus.load_done, bus.cpu_hold, bus.load_err});
            end
            checks++;
            if (wr_q.size() !== wc) begin
                failures++;
                $display("FAIL rand_count load=%0d got=%0d exp=%0d", l, wr_q.size(), wc);
            end else begin
                for (int i = 0; i < wc; i++) begin
                    checks++;
                    if (wr_q[i] !== {8'(i), model_word(d, i)}) begin
                        failures++;
                        $display("FAIL rand_word load=%0d idx=%0d got=%h exp=%h",
                                 l, i, wr_q[i], {8'(i), model_word(d, i)});
                    end
                end
            end
        end
        checks++;
        if (overlap_cnt !== 0) begin
            failures++;
            $display("FAIL ready_during_write got=%0d exp=0", overlap_cnt);
        end
    endtask

    task automatic test_full256();
        byte_q_t d;
        bit ok;
        for (int i = 0; i < 1024; i++) d.push_back(8'(i));
        wr_q.delete();
        do_start(9'd256);
        drive_stream(d, 1'b0, ok);
        @(posedge clk); #1;
        checks++;
        if (!ok || bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b0) begin
            failures++;
            $display("FAIL full_done got ok=%0d done=%b hold=%b exp ok=1 done=1 hold=0",
                     ok, bus.load_done, bus.cpu_hold);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (wr_q.size() !== 256) begin
            failures++;
            $display("FAIL full_count got=%0d exp=256", wr_q.size());
        end else begin
            checks++;
            if (wr_q[255][39:32] !== 8'hFF) begin
                failures++;
                $display("FAIL full_last_addr got=%h exp=ff", wr_q[255][39:32]);
            end
            for (int i = 0; i < 256; i++) begin
                checks++;
                if (wr_q[i] !== {8'(i), model_word(d, i)}) begin
                    failures++;
                    $display("FAIL full_word idx=%0d got=%h exp=%h",
                             i, wr_q[i], {8'(i), model_word(d, i)});
                end
            end
        end
    endtask

    task automatic test_reset_midload();
        byte_q_t d;
        bit ok;
        wr_q.delete();
        do_start(9'd4);
        d = rand_bytes(6);
        drive_stream(d, 1'b0, ok);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || outs() !== RESET_VEC) begin
            failures++;
            $display("FAIL async_reset got ok=%0d outs=%h exp=%h", ok, outs(), RESET_VEC);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (outs() !== RESET_VEC) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=%h", outs(), RESET_VEC);
        end
        wr_q.delete();
        do_start(9'd1);
        d = rand_bytes(4);
        drive_stream(d, 1'b1, ok);
        checks++;
        if (!ok || {bus.im_we, bus.im_addr, bus.im_wdata} !== {1'b1, 8'h00, model_word(d, 0)}) begin
            failures++;
            $display("FAIL fresh_load got ok=%0d we=%b addr=%h data=%h exp we=1 addr=00 data=%h",
                     ok, bus.im_we, bus.im_addr, bus.im_wdata, model_word(d, 0));
        end
        @(posedge clk); #1;
        checks++;
        if ({bus.load_done, bus.cpu_hold} !== 2'b10) begin
            failures++;
            $display("FAIL fresh_done got done/hold=%b exp=10", {bus.load_done, bus.cpu_hold});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.word_count = 9'd0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        test_reset();
        test_basic();
        test_illegal_count();
        test_timeout();
        test_random_valid();
        test_full256();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the 256 × 32-bit instruction memory. It accepts a stream of bytes over a valid/ready interface and packs them big-endian into 32-bit words. Each word is written to consecutive instruction-memory addresses starting at 0. The processor pipeline is held in reset until a load completes without error.

## Interface
- TIMEOUT, 1024: idle cycles allowed between accepted bytes while loading; range 2..65535.
- Clock  in  1  system clock; all logic is rising-edge triggered.
- Reset_  in  1  asynchronous, active-low reset.
- Start  in  1  single-cycle load request; sampled only in IDLE or DONE.
- Word_Count  in  9  number of words to load; legal range 1..256, sampled together with Start.
- Byte_In  in  8  stream data byte.
- Byte_Valid  in  1  Byte_In holds a valid byte.
- Byte_Ready  out  1  loader can accept a byte; a byte transfers when Byte_Valid and Byte_Ready are both high.
- IM_WE  out  1  instruction-memory write enable, one-cycle pulse per word.
- IM_Addr  out  8  instruction-memory word address.
- IM_WData  out  32  instruction-memory write data.
- Cpu_Hold  out  1  holds the pipeline in reset; the PC must not advance while this is high.
- Load_Done  out  1  level; last load completed successfully.
- Load_Err  out  1  level; last Start was rejected or the last load timed out.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - Start with Word_Count in 1..256: clear the word counter, byte counter, timeout counter, Load_Done and Load_Err; go to RECV.
  - Start with Word_Count = 0 or > 256: set Load_Err; stay in IDLE.
- RECV:
  - Byte_Ready = 1.
  - Each accepted byte is shifted into the assembly register: byte 0 goes to [31:24], byte 3 to [7:0].
  - After the 4th accepted byte, go to WRITE.
  - Timeout counter clears on every accepted byte and increments otherwise. When it reaches TIMEOUT-1 without a byte: set Load_Err, go to IDLE. The partial word is discarded and Cpu_Hold stays 1.
- WRITE (exactly one cycle):
  - IM_WE = 1, IM_Addr = word counter[7:0], IM_WData = assembled word; Byte_Ready = 0.
  - If word counter = Word_Count-1 (latched value): go to DONE.
  - Otherwise increment the word counter, clear the byte counter, go to RECV.
- DONE:
  - Load_Done = 1, Cpu_Hold = 0.
  - Start with a legal count re-enters RECV: Cpu_Hold returns to 1 and Load_Done clears.
  - Start with an illegal count sets Load_Err, drops Load_Done, raises Cpu_Hold and goes to IDLE.
- Start in RECV or WRITE is ignored.
- Bytes presented in IDLE, WRITE or DONE are not accepted (Byte_Ready = 0).
- Word counter is 9 bits internally; the 256th word is written at IM_Addr = 8'hFF, with no wrap beyond it.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - Byte_Ready 0, IM_WE 0, IM_Addr 8'h00, IM_WData 32'h0
  - Cpu_Hold 1, Load_Done 0, Load_Err 0
- Reset mid-load returns to IDLE immediately. The partially loaded memory is not cleared; Cpu_Hold goes to 1.
- Start accepted at edge n: Byte_Ready = 1 from cycle n+1.
- 4th byte accepted at edge m: IM_WE = 1 during cycle m+1, Byte_Ready = 0 during cycle m+1, Byte_Ready = 1 again in cycle m+2 if more words remain.
- Final write in cycle k: Load_Done = 1 and Cpu_Hold = 0 from cycle k+1.
- Peak throughput is one word per 5 cycles with Byte_Valid held high.
- Timeout: with no byte accepted since entering RECV or since the last accepted byte, Load_Err rises TIMEOUT cycles later and Byte_Ready falls in that same cycle.
- Load_Err is set one cycle after an illegal Start.

## Test plan
- Reset, then Start with Word_Count = 2 and bytes 12 34 56 78 9A BC DE F0 streamed back-to-back:
  - Write 1: IM_Addr 0, IM_WData 32'h12345678.
  - Write 2: IM_Addr 1, IM_WData 32'h9ABCDEF0.
  - Load_Done = 1 and Cpu_Hold = 0 one cycle after write 2; exactly 2 IM_WE pulses in total.
- Word_Count = 256 with incrementing data: last write at IM_Addr 8'hFF, no write at a wrapped address, Load_Done asserted.
- Byte_Valid toggled randomly:
  - Words assembled correctly.
  - No byte accepted during WRITE.
  - Byte_Valid with Byte_Ready = 0 never consumes a byte.
- TIMEOUT = 8, stream 5 bytes then stall: exactly 1 write (addr 0), then Load_Err = 1 after 8 idle cycles, state IDLE, Cpu_Hold = 1, Load_Done = 0.
- Start with Word_Count = 0 and then 300: Load_Err = 1 both times, no IM_WE, Byte_Ready stays 0. A following legal Start clears Load_Err.
- Reset_ asserted after 6 bytes of a 4-word load: all outputs at reset values asynchronously. A fresh load after release begins at IM_Addr 0.
